// File: rtl/reservation_station_param.sv
// Generic reservation station: ENTRIES slots with CDB_N-channel operand wake-up,
// oldest-ready selection and a registered valid/ready issue stage.
module reservation_station_param #(
  parameter int ENTRIES = 8,
  parameter int CDB_N   = 2,
  parameter int ROB_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 3,
  parameter int PAY_W   = 64
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              flush_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [OP_W-1:0]                   in_op,
  input  logic [DATA_W-1:0]                 in_vj,
  input  logic [DATA_W-1:0]                 in_vk,
  input  logic [ROB_W-1:0]                  in_qj,
  input  logic [ROB_W-1:0]                  in_qk,
  input  logic [ROB_W-1:0]                  in_dest,
  input  logic [PAY_W-1:0]                  in_payload,
  input  logic [CDB_N*ROB_W-1:0]            cdb_rob_id,
  input  logic [CDB_N*DATA_W-1:0]           cdb_value,
  output logic [$clog2(ENTRIES+1)-1:0]      free_count,
  output logic                              has_no_vacancy,
  output logic                              has_one_vacancy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OP_W-1:0]                   out_op,
  output logic [DATA_W-1:0]                 out_vj,
  output logic [DATA_W-1:0]                 out_vk,
  output logic [ROB_W-1:0]                  out_dest,
  output logic [PAY_W-1:0]                  out_payload
);

  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] busy;
  logic [OP_W-1:0]    op_q   [ENTRIES];
  logic [DATA_W-1:0]  vj_q   [ENTRIES];
  logic [DATA_W-1:0]  vk_q   [ENTRIES];
  logic [ROB_W-1:0]   qj_q   [ENTRIES];
  logic [ROB_W-1:0]   qk_q   [ENTRIES];
  logic [ROB_W-1:0]   dest_q [ENTRIES];
  logic [PAY_W-1:0]   pay_q  [ENTRIES];
  // older[j][i] set means slot j was dispatched before slot i
  logic [ENTRIES-1:0] older  [ENTRIES];

  logic [ENTRIES-1:0] rdy, blocked, wj_hit, wk_hit;
  logic [DATA_W-1:0]  wj_val [ENTRIES];
  logic [DATA_W-1:0]  wk_val [ENTRIES];
  logic               bj_hit, bk_hit;
  logic [DATA_W-1:0]  bj_val, bk_val;
  logic [CNT_W-1:0]   busy_cnt;
  logic [IDX_W-1:0]   alloc_idx, sel_idx;
  logic               any_ready, stage_free, issue, dispatch;

  // Lowest channel wins; tag 0 is never a match.
  function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_W-1:0] tag);
    logic              hit;
    logic [DATA_W-1:0] val;
    hit = 1'b0;
    val = '0;
    for (int unsigned c = 0; c < CDB_N; c++) begin
      if (!hit && tag != '0 && cdb_rob_id[c*ROB_W +: ROB_W] == tag) begin
        hit = 1'b1;
        val = cdb_value[c*DATA_W +: DATA_W];
      end
    end
    return {hit, val};
  endfunction

  always_comb begin
    busy_cnt  = '0;
    alloc_idx = '0;
    sel_idx   = '0;
    any_ready = 1'b0;
    rdy       = '0;
    blocked   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      busy_cnt = busy_cnt + CNT_W'(busy[i]);
      rdy[i]   = busy[i] && qj_q[i] == '0 && qk_q[i] == '0;
      {wj_hit[i], wj_val[i]} = cdb_lookup(qj_q[i]);
      {wk_hit[i], wk_val[i]} = cdb_lookup(qk_q[i]);
    end
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (!busy[i-1]) alloc_idx = IDX_W'(i-1);
    end
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      for (int unsigned j = 0; j < ENTRIES; j++) begin
        if (rdy[j] && older[j][i]) blocked[i] = 1'b1;
      end
      if (rdy[i] && !blocked[i]) begin
        any_ready = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    {bj_hit, bj_val} = cdb_lookup(in_qj);
    {bk_hit, bk_val} = cdb_lookup(in_qk);
  end

  assign free_count      = CNT_W'(ENTRIES) - busy_cnt;
  assign has_no_vacancy  = free_count == '0;
  assign has_one_vacancy = free_count == CNT_W'(1);
  assign in_ready        = !has_no_vacancy;
  assign stage_free      = !out_valid || out_ready;
  assign issue           = stage_free && any_ready;
  assign dispatch        = in_valid && in_ready;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy        <= '0;
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_vj      <= '0;
      out_vk      <= '0;
      out_dest    <= '0;
      out_payload <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
        pay_q[i]  <= '0;
        older[i]  <= '0;
      end
    end else if (flush_in) begin
      busy        <= '0;
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_vj      <= '0;
      out_vk      <= '0;
      out_dest    <= '0;
      out_payload <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) older[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (busy[i] && wj_hit[i]) begin
          vj_q[i] <= wj_val[i];
          qj_q[i] <= '0;
        end
        if (busy[i] && wk_hit[i]) begin
          vk_q[i] <= wk_val[i];
          qk_q[i] <= '0;
        end
      end
      // The issued slot is busy and the allocated one is free, so they never collide.
      if (issue) busy[sel_idx] <= 1'b0;
      if (stage_free) begin
        out_valid <= any_ready;
        if (any_ready) begin
          out_op      <= op_q[sel_idx];
          out_vj      <= vj_q[sel_idx];
          out_vk      <= vk_q[sel_idx];
          out_dest    <= dest_q[sel_idx];
          out_payload <= pay_q[sel_idx];
        end
      end
      if (dispatch) begin
        busy[alloc_idx]   <= 1'b1;
        op_q[alloc_idx]   <= in_op;
        vj_q[alloc_idx]   <= bj_hit ? bj_val : in_vj;
        vk_q[alloc_idx]   <= bk_hit ? bk_val : in_vk;
        qj_q[alloc_idx]   <= bj_hit ? '0 : in_qj;
        qk_q[alloc_idx]   <= bk_hit ? '0 : in_qk;
        dest_q[alloc_idx] <= in_dest;
        pay_q[alloc_idx]  <= in_payload;
        older[alloc_idx]  <= '0;
        for (int unsigned j = 0; j < ENTRIES; j++) begin
          if (IDX_W'(j) != alloc_idx) older[j][alloc_idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/reservation_station_param.md
Name: reservation_station_param

Overview:
- Parametrised, generic reservation station, the successor to the fixed-size BCU station.
- Holds up to ENTRIES dispatched ops and snoops CDB_N result buses for operand wake-up.
- Issues the oldest ready op through a registered valid/ready output stage, so it can feed any single-issue functional unit (ALU, BCU, MUL).
- Sits between the decoder/dispatch and a functional unit; it is drained by the ROB-driven flush.

Parameters:
ENTRIES, 8, number of station slots (>=2)
CDB_N, 2, number of CDB broadcast channels snooped
ROB_W, 4, ROB index width; index 0 means "no dependency / invalid"
DATA_W, 32, operand width
OP_W, 3, opcode width
PAY_W, 64, opaque payload carried unchanged to the unit (e.g. pc_fallthrough, pc_target)

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-low reset
flush_in  in  1  synchronous flush (misprediction)
in_valid  in  1  dispatch request
in_ready  out  1  station can accept this cycle (free_count!=0)
in_op  in  OP_W  opcode
in_vj, in_vk  in  DATA_W  operand values
in_qj, in_qk  in  ROB_W  producer ROB ids; 0 = value already valid
in_dest  in  ROB_W  destination ROB id (nonzero)
in_payload  in  PAY_W  opaque payload
cdb_rob_id  in  CDB_N*ROB_W  packed CDB tags; channel c at bits [c*ROB_W +: ROB_W]; 0 = idle
cdb_value  in  CDB_N*DATA_W  packed CDB values, same packing
free_count  out  $clog2(ENTRIES+1)  vacant slots in current state
has_no_vacancy  out  1  free_count==0
has_one_vacancy  out  1  free_count==1
out_valid  out  1  issued op present
out_ready  in  1  unit accepts op
out_op, out_vj, out_vk, out_dest, out_payload  out  matching widths  issued op fields

Behaviour:
- Reset (rst_in low, asynchronous):
  - All slots are cleared and every out_* register is 0.
  - free_count=ENTRIES and in_ready=1.
- Flush:
  - Same clearing as reset, at the clock edge.
  - Takes precedence over dispatch, wake-up and issue in that cycle; an in_valid in the flush cycle is dropped.
- Dispatch:
  - Accepted at an edge when in_valid && in_ready.
  - Writes the lowest-index free slot and stamps it as youngest.
  - in_valid while full is ignored; there is no error and the state is unchanged.
- Dispatch bypass:
  - If in_qj (or in_qk) is nonzero and equals a CDB tag in the same cycle, the slot stores that CDB value with Q=0.
  - If the tag matches several channels, the lowest channel index wins.
- Wake-up: every busy slot with Qx!=0 matching any nonzero CDB tag captures the value and clears Qx at the edge. The same lowest-channel priority applies.
- CDB tag 0 never matches.
- Ready slot: busy && Qj==0 && Qk==0, evaluated on registered state only. There is no same-cycle CDB-to-issue forwarding.
- Issue:
  - Issue happens at an edge when a ready slot exists and the output stage is free, i.e. !out_valid || out_ready.
  - The selected slot is the oldest ready slot by dispatch order, not by slot index.
  - Its fields load the out_* registers, out_valid is set and the slot is freed.
  - If no ready slot exists and the stage is being freed, out_valid goes to 0; out_* data is don't-care.
- Backpressure: while out_valid && !out_ready, all out_* stay stable and no slot is released.
- Latency:
  - An op dispatched at edge k with both operands ready reaches out_valid at edge k+1 at the earliest.
  - An op woken by the CDB at edge k issues at edge k+1 at the earliest.
  - Throughput is 1 op/cycle with out_ready held high.
- Simultaneous events:
  - Issue-free and dispatch in the same cycle are independent; the freed slot is reusable next cycle.
  - free_count reflects the registered state, so a same-cycle release does not raise in_ready.
  - Wake-up and issue in the same cycle are independent because issue uses pre-edge state.
- Age ordering survives arbitrary slot reuse; there is no index-wrap artefact.

Test Plan:
- Reset: assert rst_in low mid-run with 3 slots busy and out_valid=1 -> out_valid=0, all out_*=0, free_count=8, has_no_vacancy=0, in_ready=1, all without a clock edge.
- Fill and wake:
  - Dispatch 8 ops, dest 1..8, all with in_qj=9 -> free_count=0, has_no_vacancy=1, a 9th in_valid is ignored.
  - Then CDB ch1 sends tag 9, value 0x55 -> ops issue in order dest 1..8 on consecutive cycles (out_ready=1), each with out_vj=0x55.
- Backpressure: ready op dest=3 issued with out_ready=0 for 3 cycles -> out_valid=1 and out_dest=3 held stable, free_count unchanged; it releases one cycle after out_ready=1.
- Dispatch bypass: in_qk=5 while CDB ch0 sends tag 5, value 0xDEADBEEF and ch1 sends tag 5, value 0x1 -> out_vk=0xDEADBEEF, out_valid one edge after dispatch.
- Oldest-first:
  - Dispatch A (dest 1, qj=2), then B (dest 4, ready), then C (dest 6, ready) into recycled lower slots -> issue order B, C.
  - CDB tag 2 -> A issues next.
  - CDB tag 0 with value 0x7 wakes nothing.
- Flush: flush_in=1 with out_valid=1, out_ready=0, 5 slots busy and in_valid=1 -> next cycle out_valid=0, free_count=8, and the dispatched op never issues.
